// File: rtl/cpuDefine.sv
// Shared types for the commit/exception stage: raw exception flag vector, excodes,
// commit FSM states and bad-address source select.
package cpuDefine;

  typedef struct packed {
    logic rsvd;
    logic adef;
    logic tlbr_f;
    logic pif;
    logic ppi_f;
    logic sys;
    logic brk;
    logic ine;
    logic ipe;
    logic ale;
    logic adem;
    logic tlbr_m;
    logic pil;
    logic pis;
    logic ppi_m;
    logic pme;
  } ExcVec;

  localparam logic [5:0] EcInt  = 6'h00;
  localparam logic [5:0] EcPil  = 6'h01;
  localparam logic [5:0] EcPis  = 6'h02;
  localparam logic [5:0] EcPif  = 6'h03;
  localparam logic [5:0] EcPme  = 6'h04;
  localparam logic [5:0] EcPpi  = 6'h07;
  localparam logic [5:0] EcAde  = 6'h08;
  localparam logic [5:0] EcAle  = 6'h09;
  localparam logic [5:0] EcSys  = 6'h0B;
  localparam logic [5:0] EcBrk  = 6'h0C;
  localparam logic [5:0] EcIne  = 6'h0D;
  localparam logic [5:0] EcIpe  = 6'h0E;
  localparam logic [5:0] EcTlbr = 6'h3F;

  typedef enum logic [1:0] {StRun, StFlush, StIdleWait} CommitState;

  typedef enum logic [1:0] {BadvNone, BadvPc, BadvVaddr} BadvSel;

endpackage

// File: rtl/exc_prio.sv
// Combinational exception priority encoder: picks the single highest-priority event
// (interrupt first) and reports its excode, esubcode and bad-address source.
import cpuDefine::*;

module exc_prio (
  input  ExcVec       i_exc,
  input  logic        i_int_pending,
  output logic        o_hit,
  output logic [5:0]  o_excode,
  output logic [8:0]  o_esubcode,
  output BadvSel      o_badv_sel
);

  logic w_unused;
  assign w_unused = i_exc.rsvd;

  always_comb begin
    o_hit      = 1'b1;
    o_excode   = EcInt;
    o_esubcode = 9'd0;
    o_badv_sel = BadvNone;
    if (i_int_pending) begin
      o_excode = EcInt;
    end else if (i_exc.adef) begin
      o_excode   = EcAde;
      o_badv_sel = BadvPc;
    end else if (i_exc.tlbr_f) begin
      o_excode   = EcTlbr;
      o_badv_sel = BadvPc;
    end else if (i_exc.pif) begin
      o_excode   = EcPif;
      o_badv_sel = BadvPc;
    end else if (i_exc.ppi_f) begin
      o_excode   = EcPpi;
      o_badv_sel = BadvPc;
    end else if (i_exc.sys) begin
      o_excode = EcSys;
    end else if (i_exc.brk) begin
      o_excode = EcBrk;
    end else if (i_exc.ine) begin
      o_excode = EcIne;
    end else if (i_exc.ipe) begin
      o_excode = EcIpe;
    end else if (i_exc.ale) begin
      o_excode   = EcAle;
      o_badv_sel = BadvVaddr;
    end else if (i_exc.adem) begin
      o_excode   = EcAde;
      o_esubcode = 9'd1;
      o_badv_sel = BadvVaddr;
    end else if (i_exc.tlbr_m) begin
      o_excode   = EcTlbr;
      o_badv_sel = BadvVaddr;
    end else if (i_exc.pil) begin
      o_excode   = EcPil;
      o_badv_sel = BadvVaddr;
    end else if (i_exc.pis) begin
      o_excode   = EcPis;
      o_badv_sel = BadvVaddr;
    end else if (i_exc.ppi_m) begin
      o_excode   = EcPpi;
      o_badv_sel = BadvVaddr;
    end else if (i_exc.pme) begin
      o_excode   = EcPme;
      o_badv_sel = BadvVaddr;
    end else begin
      o_hit = 1'b0;
    end
  end

endmodule

// File: rtl/exc_commit.sv
// Commit-stage exception/interrupt resolution with flush and idle-wait sequencing.
// All outputs are registered; event pulses appear the cycle after a commit is accepted.
import cpuDefine::*;

module exc_commit (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wb_valid,
  output logic        o_wb_ready,
  input  logic [31:0] i_wb_pc,
  input  logic [31:0] i_wb_vaddr,
  input  ExcVec       i_wb_exc,
  input  logic        i_wb_ertn,
  input  logic        i_wb_idle,
  input  logic        i_wb_refetch,
  input  logic        i_ie,
  input  logic [11:0] i_lie,
  input  logic [11:0] i_is,
  output logic        o_is_exc,
  output logic [5:0]  o_excode,
  output logic [8:0]  o_esubcode,
  output logic [31:0] o_badvaddr,
  output logic [31:0] o_csr_pc,
  output logic        o_is_ertn,
  output logic        o_is_fetch_again,
  output logic        o_is_idle,
  output logic        o_flush_pipe
);

  CommitState  r_state;
  logic        r_flush_cnt;
  logic [31:0] r_idle_pc;

  logic        w_int_pending;
  logic        w_accept;
  logic        w_hit;
  logic [5:0]  w_excode;
  logic [8:0]  w_esubcode;
  BadvSel      w_badv_sel;
  logic [31:0] w_badv;

  assign w_int_pending = i_ie & (|(i_lie & i_is));
  assign w_accept      = i_wb_valid & o_wb_ready;

  exc_prio u_exc_prio (
    .i_exc         (i_wb_exc),
    .i_int_pending (w_int_pending),
    .o_hit         (w_hit),
    .o_excode      (w_excode),
    .o_esubcode    (w_esubcode),
    .o_badv_sel    (w_badv_sel)
  );

  always_comb begin
    w_badv = 32'd0;
    case (w_badv_sel)
      BadvPc:    w_badv = i_wb_pc;
      BadvVaddr: w_badv = i_wb_vaddr;
      default:   w_badv = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= StRun;
      r_flush_cnt      <= 1'b0;
      r_idle_pc        <= 32'd0;
      o_wb_ready       <= 1'b1;
      o_flush_pipe     <= 1'b0;
      o_is_exc         <= 1'b0;
      o_is_ertn        <= 1'b0;
      o_is_fetch_again <= 1'b0;
      o_is_idle        <= 1'b0;
      o_excode         <= 6'd0;
      o_esubcode       <= 9'd0;
      o_badvaddr       <= 32'd0;
      o_csr_pc         <= 32'd0;
    end else begin
      o_is_exc         <= 1'b0;
      o_is_ertn        <= 1'b0;
      o_is_fetch_again <= 1'b0;
      o_is_idle        <= 1'b0;
      unique case (r_state)
        StRun: begin
          if (w_accept) begin
            // Anything that redirects fetch enters the two-cycle flush window.
            if (w_hit || i_wb_ertn || i_wb_refetch) begin
              r_state      <= StFlush;
              r_flush_cnt  <= 1'b0;
              o_wb_ready   <= 1'b0;
              o_flush_pipe <= 1'b1;
              o_csr_pc     <= i_wb_pc;
              if (w_hit) begin
                o_is_exc   <= 1'b1;
                o_excode   <= w_excode;
                o_esubcode <= w_esubcode;
                o_badvaddr <= w_badv;
              end else if (i_wb_ertn) begin
                o_is_ertn <= 1'b1;
              end else begin
                o_is_fetch_again <= 1'b1;
              end
            end else if (i_wb_idle) begin
              r_state      <= StIdleWait;
              r_idle_pc    <= i_wb_pc;
              o_wb_ready   <= 1'b0;
              o_flush_pipe <= 1'b1;
              o_is_idle    <= 1'b1;
            end
          end
        end
        StFlush: begin
          if (r_flush_cnt) begin
            r_state      <= StRun;
            r_flush_cnt  <= 1'b0;
            o_wb_ready   <= 1'b1;
            o_flush_pipe <= 1'b0;
          end else begin
            r_flush_cnt <= 1'b1;
          end
        end
        StIdleWait: begin
          if (w_int_pending) begin
            r_state     <= StFlush;
            r_flush_cnt <= 1'b0;
            o_is_exc    <= 1'b1;
            o_excode    <= EcInt;
            o_esubcode  <= 9'd0;
            o_badvaddr  <= 32'd0;
            o_csr_pc    <= r_idle_pc + 32'd4;
          end
        end
        default: begin
          r_state      <= StRun;
          o_wb_ready   <= 1'b1;
          o_flush_pipe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exc_commit.sv
// Directed bench for exc_commit: expected events are queued at drive time and
// compared against the registered outputs the cycle after acceptance.
import cpuDefine::*;

module tb_exc_commit;

  logic        clk;
  logic        reset;
  logic        i_wb_valid;
  logic        o_wb_ready;
  logic [31:0] i_wb_pc;
  logic [31:0] i_wb_vaddr;
  ExcVec       i_wb_exc;
  logic        i_wb_ertn;
  logic        i_wb_idle;
  logic        i_wb_refetch;
  logic        i_ie;
  logic [11:0] i_lie;
  logic [11:0] i_is;
  logic        o_is_exc;
  logic [5:0]  o_excode;
  logic [8:0]  o_esubcode;
  logic [31:0] o_badvaddr;
  logic [31:0] o_csr_pc;
  logic        o_is_ertn;
  logic        o_is_fetch_again;
  logic        o_is_idle;
  logic        o_flush_pipe;

  exc_commit dut (
    .clk              (clk),
    .reset            (reset),
    .i_wb_valid       (i_wb_valid),
    .o_wb_ready       (o_wb_ready),
    .i_wb_pc          (i_wb_pc),
    .i_wb_vaddr       (i_wb_vaddr),
    .i_wb_exc         (i_wb_exc),
    .i_wb_ertn        (i_wb_ertn),
    .i_wb_idle        (i_wb_idle),
    .i_wb_refetch     (i_wb_refetch),
    .i_ie             (i_ie),
    .i_lie            (i_lie),
    .i_is             (i_is),
    .o_is_exc         (o_is_exc),
    .o_excode         (o_excode),
    .o_esubcode       (o_esubcode),
    .o_badvaddr       (o_badvaddr),
    .o_csr_pc         (o_csr_pc),
    .o_is_ertn        (o_is_ertn),
    .o_is_fetch_again (o_is_fetch_again),
    .o_is_idle        (o_is_idle),
    .o_flush_pipe     (o_flush_pipe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int KNone = 0;
  localparam int KExc  = 1;
  localparam int KErtn = 2;
  localparam int KRef  = 3;
  localparam int KIdle = 4;

  typedef struct {
    int          kind;
    logic [5:0]  ec;
    logic [8:0]  sub;
    logic [31:0] badv;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  function automatic exp_t mk(int kind, logic [5:0] ec, logic [8:0] sub,
                              logic [31:0] badv, logic [31:0] pc);
    exp_t e;
    e.kind = kind;
    e.ec   = ec;
    e.sub  = sub;
    e.badv = badv;
    e.pc   = pc;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (o_wb_ready !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk("ready_timeout", {31'd0, o_wb_ready}, 32'd1);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    logic [3:0] pv;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    case (e.kind)
      KExc:    pv = 4'b1000;
      KErtn:   pv = 4'b0100;
      KRef:    pv = 4'b0010;
      KIdle:   pv = 4'b0001;
      default: pv = 4'b0000;
    endcase
    chk({tag, "_pulses"}, {28'd0, o_is_exc, o_is_ertn, o_is_fetch_again, o_is_idle},
        {28'd0, pv});
    chk({tag, "_ready"}, {31'd0, o_wb_ready}, (e.kind == KNone) ? 32'd1 : 32'd0);
    if (e.kind == KExc) begin
      chk({tag, "_excode"}, {26'd0, o_excode}, {26'd0, e.ec});
      chk({tag, "_esub"}, {23'd0, o_esubcode}, {23'd0, e.sub});
      chk({tag, "_badv"}, o_badvaddr, e.badv);
    end
    if (e.kind == KExc || e.kind == KErtn || e.kind == KRef)
      chk({tag, "_csr_pc"}, o_csr_pc, e.pc);
  endtask

  task automatic commit(input string tag, input logic [31:0] pc, input logic [31:0] va,
                        input ExcVec ex, input logic ertn, input logic idle,
                        input logic refetch, input exp_t e);
    wait_ready();
    i_wb_valid   = 1'b1;
    i_wb_pc      = pc;
    i_wb_vaddr   = va;
    i_wb_exc     = ex;
    i_wb_ertn    = ertn;
    i_wb_idle    = idle;
    i_wb_refetch = refetch;
    exp_q.push_back(e);
    tick();
    i_wb_valid   = 1'b0;
    i_wb_exc     = '0;
    i_wb_ertn    = 1'b0;
    i_wb_idle    = 1'b0;
    i_wb_refetch = 1'b0;
    check_out(tag);
  endtask

  task automatic set_int(input logic on);
    i_ie  = on;
    i_lie = on ? 12'h800 : 12'h000;
    i_is  = on ? 12'h800 : 12'h000;
  endtask

  ExcVec ex;

  initial begin
    reset        = 1'b1;
    i_wb_valid   = 1'b0;
    i_wb_pc      = 32'd0;
    i_wb_vaddr   = 32'd0;
    i_wb_exc     = '0;
    i_wb_ertn    = 1'b0;
    i_wb_idle    = 1'b0;
    i_wb_refetch = 1'b0;
    set_int(1'b0);
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_ready", {31'd0, o_wb_ready}, 32'd1);
    chk("rst_pulses", {28'd0, o_is_exc, o_is_ertn, o_is_fetch_again, o_is_idle}, 32'd0);
    chk("rst_flush", {31'd0, o_flush_pipe}, 32'd0);
    chk("rst_excode", {26'd0, o_excode}, 32'd0);
    chk("rst_csr_pc", o_csr_pc, 32'd0);
    chk("rst_badv", o_badvaddr, 32'd0);

    ex = '0;
    commit("plain", 32'h1c00_0000, 32'd0, ex, 1'b0, 1'b0, 1'b0, mk(KNone, 0, 0, 0, 0));

    ex = '0; ex.sys = 1'b1;
    commit("sys", 32'h1c00_0100, 32'd0, ex, 1'b0, 1'b0, 1'b0,
           mk(KExc, 6'h0B, 9'd0, 32'd0, 32'h1c00_0100));
    chk("sys_flush1", {31'd0, o_flush_pipe}, 32'd1);
    tick();
    chk("sys_ready2", {31'd0, o_wb_ready}, 32'd0);
    chk("sys_flush2", {31'd0, o_flush_pipe}, 32'd1);
    chk("sys_pulse2", {31'd0, o_is_exc}, 32'd0);
    tick();
    chk("sys_ready3", {31'd0, o_wb_ready}, 32'd1);
    chk("sys_flush3", {31'd0, o_flush_pipe}, 32'd0);

    set_int(1'b1);
    ex = '0; ex.ale = 1'b1;
    commit("int_ale", 32'h1c00_0110, 32'h0000_1234, ex, 1'b0, 1'b0, 1'b0,
           mk(KExc, 6'h00, 9'd0, 32'd0, 32'h1c00_0110));
    set_int(1'b0);

    ex = '0; ex.ale = 1'b1; ex.pil = 1'b1;
    commit("ale_pil", 32'h1c00_0120, 32'h8000_0003, ex, 1'b0, 1'b0, 1'b0,
           mk(KExc, 6'h09, 9'd0, 32'h8000_0003, 32'h1c00_0120));

    ex = '0; ex.adef = 1'b1;
    commit("adef", 32'hffff_fffd, 32'h0000_0040, ex, 1'b0, 1'b0, 1'b0,
           mk(KExc, 6'h08, 9'd0, 32'hffff_fffd, 32'hffff_fffd));

    ex = '0; ex.adem = 1'b1;
    commit("adem", 32'h1c00_0130, 32'hffff_fffd, ex, 1'b0, 1'b0, 1'b0,
           mk(KExc, 6'h08, 9'd1, 32'hffff_fffd, 32'h1c00_0130));

    ex = '0; ex.tlbr_f = 1'b1; ex.pif = 1'b1; ex.pme = 1'b1;
    commit("tlbr_f", 32'h1c00_0140, 32'h0000_0050, ex, 1'b0, 1'b0, 1'b0,
           mk(KExc, 6'h3F, 9'd0, 32'h1c00_0140, 32'h1c00_0140));

    ex = '0; ex.pme = 1'b1;
    commit("pme", 32'h1c00_0144, 32'h0000_0060, ex, 1'b0, 1'b0, 1'b0,
           mk(KExc, 6'h04, 9'd0, 32'h0000_0060, 32'h1c00_0144));

    ex = '0; ex.brk = 1'b1;
    commit("ertn_brk", 32'h1c00_0150, 32'd0, ex, 1'b1, 1'b0, 1'b0,
           mk(KExc, 6'h0C, 9'd0, 32'd0, 32'h1c00_0150));

    ex = '0;
    commit("ertn", 32'h1c00_0160, 32'd0, ex, 1'b1, 1'b0, 1'b0,
           mk(KErtn, 0, 0, 0, 32'h1c00_0160));

    commit("refetch", 32'h1c00_0170, 32'd0, ex, 1'b0, 1'b0, 1'b1,
           mk(KRef, 0, 0, 0, 32'h1c00_0170));

    // Interrupt pending with no valid commit: no pulse until the next commit.
    wait_ready();
    set_int(1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("noval_int", {28'd0, o_is_exc, o_is_ertn, o_is_fetch_again, o_is_idle}, 32'd0);
    end
    commit("int_next", 32'h1c00_0180, 32'd0, ex, 1'b0, 1'b0, 1'b0,
           mk(KExc, 6'h00, 9'd0, 32'd0, 32'h1c00_0180));
    set_int(1'b0);

    commit("idle", 32'h1c00_0200, 32'd0, ex, 1'b0, 1'b1, 1'b0, mk(KIdle, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) begin
      chk("idle_ready", {31'd0, o_wb_ready}, 32'd0);
      chk("idle_flush", {31'd0, o_flush_pipe}, 32'd1);
      if (i > 0) chk("idle_noexc", {31'd0, o_is_exc | o_is_idle}, 32'd0);
      tick();
    end
    set_int(1'b1);
    exp_q.push_back(mk(KExc, 6'h00, 9'd0, 32'd0, 32'h1c00_0204));
    tick();
    check_out("idle_int");
    set_int(1'b0);

    commit("idle_wrap", 32'hffff_fffc, 32'd0, ex, 1'b0, 1'b1, 1'b0, mk(KIdle, 0, 0, 0, 0));
    tick();
    set_int(1'b1);
    exp_q.push_back(mk(KExc, 6'h00, 9'd0, 32'd0, 32'h0000_0000));
    tick();
    check_out("idle_wrap_int");
    set_int(1'b0);

    // Reset during the second FLUSH cycle.
    ex = '0; ex.ine = 1'b1;
    commit("ine", 32'h1c00_0300, 32'd0, ex, 1'b0, 1'b0, 1'b0,
           mk(KExc, 6'h0D, 9'd0, 32'd0, 32'h1c00_0300));
    tick();
    chk("rstf_ready_pre", {31'd0, o_wb_ready}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstf_ready", {31'd0, o_wb_ready}, 32'd1);
    chk("rstf_pulses", {28'd0, o_is_exc, o_is_ertn, o_is_fetch_again, o_is_idle}, 32'd0);
    chk("rstf_flush", {31'd0, o_flush_pipe}, 32'd0);
    chk("rstf_excode", {26'd0, o_excode}, 32'd0);
    tick();
    chk("rstf_ready_hold", {31'd0, o_wb_ready}, 32'd1);

    chk("sb_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
